// File: rtl/mult_arb_ctrl.sv
// Two-requester arbiter sharing one 3x3 gate-level unsigned multiplier.
// Optional per-requester grant counters are enabled with `define MULT_ARB_CNT_EN.

module mult3x3_gate (
    input  logic [2:0] i_a,
    input  logic [2:0] i_b,
    output logic [5:0] o_p
);
    logic [2:0] w_pp0, w_pp1, w_pp2;
    logic       w_c10, w_s11, w_c11, w_s12, w_c12, w_c20, w_c21;

    assign w_pp0 = i_a & {3{i_b[0]}};
    assign w_pp1 = i_a & {3{i_b[1]}};
    assign w_pp2 = i_a & {3{i_b[2]}};

    // First ripple row: pp0 + (pp1 << 1)
    assign o_p[0] = w_pp0[0];
    assign o_p[1] = w_pp0[1] ^ w_pp1[0];
    assign w_c10  = w_pp0[1] & w_pp1[0];
    assign w_s11  = w_pp0[2] ^ w_pp1[1] ^ w_c10;
    assign w_c11  = (w_pp0[2] & w_pp1[1]) | (w_c10 & (w_pp0[2] ^ w_pp1[1]));
    assign w_s12  = w_pp1[2] ^ w_c11;
    assign w_c12  = w_pp1[2] & w_c11;

    // Second ripple row: row sum + (pp2 << 2)
    assign o_p[2] = w_s11 ^ w_pp2[0];
    assign w_c20  = w_s11 & w_pp2[0];
    assign o_p[3] = w_s12 ^ w_pp2[1] ^ w_c20;
    assign w_c21  = (w_s12 & w_pp2[1]) | (w_c20 & (w_s12 ^ w_pp2[1]));
    assign o_p[4] = w_c12 ^ w_pp2[2] ^ w_c21;
    assign o_p[5] = (w_c12 & w_pp2[2]) | (w_c21 & (w_c12 ^ w_pp2[2]));
endmodule

module mult_arb_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [2:0] req0_a,
    input  logic [2:0] req0_b,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [2:0] req1_a,
    input  logic [2:0] req1_b,
    output logic       req1_ready,
    output logic       resp_valid,
    output logic       resp_id,
    output logic [5:0] resp_p,
    input  logic       resp_ready
`ifdef MULT_ARB_CNT_EN
    ,
    output logic [7:0] gnt_cnt0,
    output logic [7:0] gnt_cnt1
`endif
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     r_state, w_state_nxt;
    logic       r_ptr;
    logic       r_id;
    logic [2:0] r_a, r_b;
    logic [5:0] r_p;
    logic       w_gnt0, w_gnt1;
    logic [5:0] w_prod;

    mult3x3_gate u_mult (
        .i_a (r_a),
        .i_b (r_b),
        .o_p (w_prod)
    );

    // r_ptr == 0 favours requester 0 on contention; a lone request always wins
    always_comb begin
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (req0_valid && (!req1_valid || !r_ptr)) begin
                    w_gnt0      = 1'b1;
                    w_state_nxt = CALC;
                end else if (req1_valid) begin
                    w_gnt1      = 1'b1;
                    w_state_nxt = CALC;
                end
            end
            CALC:    w_state_nxt = RESP;
            RESP:    if (resp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Readies are gated by rst_n so they drop the instant reset asserts
    assign req0_ready = w_gnt0 & rst_n;
    assign req1_ready = w_gnt1 & rst_n;
    assign resp_valid = (r_state == RESP);
    assign resp_id    = r_id;
    assign resp_p     = r_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= 1'b0;
            r_id    <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_p     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_gnt0 || w_gnt1) begin
                r_ptr <= w_gnt0;
                r_id  <= w_gnt1;
                r_a   <= w_gnt1 ? req1_a : req0_a;
                r_b   <= w_gnt1 ? req1_b : req0_b;
            end
            if (r_state == CALC) begin
                r_p <= w_prod;
            end
        end
    end

`ifdef MULT_ARB_CNT_EN
    logic [7:0] r_cnt0, r_cnt1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_gnt0 && (r_cnt0 != 8'hFF)) r_cnt0 <= r_cnt0 + 8'd1;
            if (w_gnt1 && (r_cnt1 != 8'hFF)) r_cnt1 <= r_cnt1 + 8'd1;
        end
    end

    assign gnt_cnt0 = r_cnt0;
    assign gnt_cnt1 = r_cnt1;
`endif
endmodule

// File: tb/tb_mult_arb_ctrl.sv
// Directed bench for mult_arb_ctrl: expected {id, product} entries are queued at
// each handshake and checked when the response appears.

module tb_mult_arb_ctrl;
    logic       clk;
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic [2:0] req0_a, req0_b, req1_a, req1_b;
    logic       req0_ready, req1_ready;
    logic       resp_valid, resp_id, resp_ready;
    logic [5:0] resp_p;
`ifdef MULT_ARB_CNT_EN
    logic [7:0] gnt_cnt0, gnt_cnt1;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [6:0]  sb[$];

    mult_arb_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_p     (resp_p),
        .resp_ready (resp_ready)
`ifdef MULT_ARB_CNT_EN
        ,
        .gnt_cnt0   (gnt_cnt0),
        .gnt_cnt1   (gnt_cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] prod(input logic [2:0] a, input logic [2:0] b);
        logic [5:0] x, y;
        x = {3'b000, a};
        y = {3'b000, b};
        return x * y;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge with the DUT in IDLE; leaves it in IDLE
    task automatic transact(input logic v0, input logic [2:0] a0, input logic [2:0] b0,
                            input logic v1, input logic [2:0] a1, input logic [2:0] b1,
                            input logic exp_id, input int unsigned hold);
        logic [6:0] exp;
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        resp_ready = 1'b0;
        @(negedge clk);
        chk("hs_rdy0", 8'(req0_ready), 8'(exp_id == 1'b0));
        chk("hs_rdy1", 8'(req1_ready), 8'(exp_id == 1'b1));
        chk("hs_idle_valid", 8'(resp_valid), 8'd0);
        if (exp_id) sb.push_back({1'b1, prod(a1, b1)});
        else        sb.push_back({1'b0, prod(a0, b0)});
        @(posedge clk); #1;
        req0_a = ~a0; req0_b = ~b0;
        req1_a = ~a1; req1_b = ~b1;
        @(negedge clk);
        chk("calc_rdy", {6'd0, req0_ready, req1_ready}, 8'd0);
        chk("calc_valid", 8'(resp_valid), 8'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("resp_valid", 8'(resp_valid), 8'd1);
        chk("resp_rdy", {6'd0, req0_ready, req1_ready}, 8'd0);
        exp = sb.pop_front();
        chk("resp_id", 8'(resp_id), 8'(exp[6]));
        chk("resp_p", 8'(resp_p), 8'(exp[5:0]));
        for (int unsigned i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("stall_valid", 8'(resp_valid), 8'd1);
            chk("stall_data", {1'b0, resp_id, resp_p}, {1'b0, exp});
            chk("stall_rdy", {6'd0, req0_ready, req1_ready}, 8'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_a = 3'd3; req0_b = 3'd5;
        req1_valid = 1'b1; req1_a = 3'd1; req1_b = 3'd1;
        resp_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_rdy", {6'd0, req0_ready, req1_ready}, 8'd0);
        chk("rst_valid", 8'(resp_valid), 8'd0);
        chk("rst_id", 8'(resp_id), 8'd0);
        chk("rst_p", 8'(resp_p), 8'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Lone requests, including one against the pointer and a zero operand
        transact(1'b1, 3'd3, 3'd5, 1'b0, 3'd0, 3'd0, 1'b0, 0);
        transact(1'b1, 3'd0, 3'd5, 1'b0, 3'd0, 3'd0, 1'b0, 0);
        transact(1'b0, 3'd0, 3'd0, 1'b1, 3'd6, 3'd4, 1'b1, 0);

        // Continuous contention alternates 0,1,0,1
        transact(1'b1, 3'd2, 3'd2, 1'b1, 3'd7, 3'd7, 1'b0, 0);
        transact(1'b1, 3'd2, 3'd2, 1'b1, 3'd7, 3'd7, 1'b1, 0);
        transact(1'b1, 3'd2, 3'd2, 1'b1, 3'd7, 3'd7, 1'b0, 0);
        transact(1'b1, 3'd2, 3'd2, 1'b1, 3'd7, 3'd7, 1'b1, 0);

        // Ten-cycle consumer stall with both requesters waiting
        transact(1'b1, 3'd4, 3'd5, 1'b1, 3'd1, 3'd1, 1'b0, 10);

        // Reset asserted mid-CALC of a req1 7*7 request
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 3'd7; req1_b = 3'd7;
        @(negedge clk);
        chk("idle_after_resp", 8'(resp_valid), 8'd0);
        chk("mid_hs_rdy1", 8'(req1_ready), 8'd1);
        @(posedge clk); #1;
        req0_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 8'(resp_valid), 8'd0);
        chk("midrst_id", 8'(resp_id), 8'd0);
        chk("midrst_p", 8'(resp_p), 8'd0);
        chk("midrst_rdy", {6'd0, req0_ready, req1_ready}, 8'd0);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_stale_valid", 8'(resp_valid), 8'd0);
        end
        @(posedge clk); #1;

        // Pointer must be back at requester 0 after reset
        transact(1'b1, 3'd1, 3'd6, 1'b1, 3'd2, 3'd3, 1'b0, 0);

        // Exhaustive operand sweep through requester 1
        for (int unsigned a = 0; a < 8; a++) begin
            for (int unsigned b = 0; b < 8; b++) begin
                transact(1'b0, 3'd0, 3'd0, 1'b1, 3'(a), 3'(b), 1'b1, 0);
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

`ifdef MULT_ARB_CNT_EN
        rst_n = 1'b0;
        #1;
        chk("cnt0_rst", gnt_cnt0, 8'd0);
        chk("cnt1_rst", gnt_cnt1, 8'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int unsigned i = 0; i < 300; i++) begin
            transact(1'b1, 3'(i), 3'(i >> 3), 1'b0, 3'd0, 3'd0, 1'b0, 0);
            if (i == 9) chk("cnt0_ten", gnt_cnt0, 8'd10);
        end
        req0_valid = 1'b0;
        @(negedge clk);
        chk("cnt0_sat", gnt_cnt0, 8'd255);
        chk("cnt1_zero", gnt_cnt1, 8'd0);
`endif

        if (sb.size() != 0) begin
            errors++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mult_arb_ctrl.md
MULT_ARB_CTRL -- requirements
Module: mult_arb_ctrl

Interface
REQ-001 SHALL have no parameters; operand width is fixed at 3 bits and product width at 6 bits.
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: req0_valid  input  1  requester 0 has operands.
REQ-005 SHALL have port: req0_a, req0_b  input  3 each  requester 0 operands.
REQ-006 SHALL have port: req0_ready  output  1  requester 0 operands accepted this cycle.
REQ-007 SHALL have ports req1_valid, req1_a, req1_b and req1_ready, identical in direction, width and meaning to the requester 0 ports, for requester 1.
REQ-008 SHALL have port: resp_valid  output  1  result available.
REQ-009 SHALL have port: resp_id  output  1  requester owning the result.
REQ-010 SHALL have port: resp_p  output  6  unsigned product A*B.
REQ-011 SHALL have port: resp_ready  input  1  consumer takes the result.

Function
REQ-012 SHALL instantiate exactly one 3x3 unsigned gate-level multiplier, shared by both requesters.
REQ-013 SHALL implement FSM IDLE -> CALC -> RESP -> IDLE, with 2-bit state encoding.
REQ-014 IDLE: if any reqN_valid is high, SHALL grant one requester, assert only that reqN_ready combinationally, latch its operands and id, and go to CALC.
REQ-015 IDLE with no valid request: SHALL assert no ready and stay in IDLE.
REQ-016 Arbitration SHALL be round-robin: a 1-bit priority pointer favours requester 0 after reset and toggles to the non-granted requester after each grant.
REQ-017 A lone valid request SHALL be granted regardless of the pointer.
REQ-018 CALC: SHALL register the multiplier output of the latched operands into resp_p and go to RESP; no ready SHALL be asserted.
REQ-019 RESP: resp_valid SHALL be 1; resp_p and resp_id SHALL be held stable until resp_ready is high.
REQ-020 RESP with resp_ready high: SHALL drop to IDLE next cycle; no grant SHALL occur in the same cycle.
REQ-021 Latency: a handshake in cycle N SHALL give resp_valid high in cycle N+2; minimum spacing between grants is 3 cycles.
REQ-022 Operand changes after the handshake SHALL NOT affect the pending result.
REQ-023 7*7 SHALL give 49 (6'b110001); 0*x SHALL give 0.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, pointer = 0, resp_valid = 0, resp_id = 0, resp_p = 0, and both ready outputs to 0.
REQ-025 Reset during CALC or RESP SHALL discard the pending result; no resp_valid SHALL appear after release until a new grant.
REQ-026 The first grant SHALL be possible in the first rising edge with rst_n high.

Configuration
REQ-027 Macro MULT_ARB_CNT_EN defined: SHALL add outputs gnt_cnt0 and gnt_cnt1 (8 bits each), which count grants per requester, saturate at 255 and reset to 0.
REQ-028 Macro MULT_ARB_CNT_EN undefined: those ports and their counters SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-029 Reset, then req0 only with a=3, b=5 -> req0_ready for 1 cycle; 2 cycles later resp_valid=1, resp_id=0, resp_p=15.
REQ-030 Both valid continuously, resp_ready=1, with req0 a=2,b=2 and req1 a=7,b=7 -> grants alternate 0,1,0,1; products alternate 4 and 49.
REQ-031 resp_ready=0 for 10 cycles in RESP -> resp_valid and resp_p stay stable; no readyN asserted; after resp_ready=1, IDLE next cycle.
REQ-032 rst_n pulsed low mid-CALC -> outputs 0 immediately; no stale resp_valid after release.
REQ-033 Exhaustive sweep of all 64 operand pairs through req1 -> each resp_p equals a*b.
REQ-034 With MULT_ARB_CNT_EN, 300 grants to req0 -> gnt_cnt0 = 255, gnt_cnt1 = 0.
